// File: rtl/dbram_stream_reader.sv
// Double-buffered RAM: the writer fills one bank while the reader streams
// the other out over a valid/ready port at one word per cycle.
module dbram_stream_reader #(
   parameter int AWIDTH    = 11,
   parameter int NUM_WORDS = 2048,
   parameter int DWIDTH    = 60
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              wr_commit,
   input  logic [AWIDTH:0]   wr_len,
   output logic              wr_bank,
   output logic              wr_ready,
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last,
   output logic              rd_bank
);

   typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bank_t;
   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_t;

   localparam logic [AWIDTH:0] LP_NW  = (AWIDTH+1)'(NUM_WORDS);
   localparam logic [AWIDTH:0] LP_ONE = (AWIDTH+1)'(1);

   logic [DWIDTH-1:0] r_mem [2][NUM_WORDS];
   bank_t             r_bst [2];
   logic [AWIDTH:0]   r_blen [2];
   logic              r_wr_bank;
   logic              r_rd_bank;
   state_t            r_state;
   state_t            w_next;
   logic [AWIDTH:0]   r_raddr;
   logic              r_infl;
   logic              r_infl_last;
   logic [DWIDTH-1:0] r_mem_q;
   logic              r_out_v;
   logic              r_out_last;
   logic [DWIDTH-1:0] r_out_d;
   logic              r_sk_v;
   logic              r_sk_last;
   logic [DWIDTH-1:0] r_sk_d;

   logic              w_wr_ok;
   logic              w_commit;
   logic [AWIDTH:0]   w_len_c;
   logic              w_xfer;
   logic              w_last_xfer;
   logic              w_cur_full;
   logic              w_oth_full;
   logic              w_more;
   logic [1:0]        w_occ;
   logic              w_room;
   logic              w_issue;
   logic              w_iss_bank;
   logic [AWIDTH:0]   w_iss_addr;
   logic              w_iss_last;
   logic              w_claim;
   logic              w_free;

   assign w_wr_ok     = (r_bst[r_wr_bank] == B_EMPTY);
   assign w_commit    = wr_commit && w_wr_ok && (wr_len != '0);
   assign w_len_c     = (wr_len > LP_NW) ? LP_NW : wr_len;
   assign w_xfer      = r_out_v && rd_ready;
   assign w_last_xfer = w_xfer && r_out_last;
   assign w_cur_full  = (r_bst[r_rd_bank] == B_FULL);
   assign w_oth_full  = (r_bst[~r_rd_bank] == B_FULL);
   assign w_more      = (r_raddr < r_blen[r_rd_bank]);
   // output + skid hold two words; a read in flight reserves one of them
   assign w_occ  = {1'b0, r_out_v} + {1'b0, r_sk_v} + {1'b0, r_infl};
   assign w_room = ((w_occ - {1'b0, w_xfer}) < 2'd2);
   assign w_iss_last = (w_iss_addr == (r_blen[w_iss_bank] - LP_ONE));

   assign wr_bank  = r_wr_bank;
   assign wr_ready = w_wr_ok;
   assign rd_data  = r_out_d;
   assign rd_valid = r_out_v;
   assign rd_last  = r_out_last;
   assign rd_bank  = r_rd_bank;

   always_ff @(posedge clk) begin
      if (wr_en && w_wr_ok)
         r_mem[r_wr_bank][wr_addr] <= wr_data;
      if (w_issue)
         r_mem_q <= r_mem[w_iss_bank][w_iss_addr[AWIDTH-1:0]];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (w_cur_full) w_next = S_PRIME;
         S_PRIME:
            w_next = S_STREAM;
         S_STREAM:
            if (w_last_xfer) w_next = w_oth_full ? S_PRIME : S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_issue    = 1'b0;
      w_iss_bank = r_rd_bank;
      w_iss_addr = r_raddr;
      w_claim    = 1'b0;
      w_free     = 1'b0;
      unique case (r_state)
         S_IDLE:
            if (w_cur_full) begin
               w_claim    = 1'b1;
               w_issue    = 1'b1;
               w_iss_addr = '0;
            end
         S_PRIME:
            w_issue = w_more && w_room;
         S_STREAM:
            if (w_last_xfer) begin
               w_free = 1'b1;
               if (w_oth_full) begin
                  w_claim    = 1'b1;
                  w_issue    = 1'b1;
                  w_iss_bank = ~r_rd_bank;
                  w_iss_addr = '0;
               end
            end else begin
               w_issue = w_more && w_room;
            end
         default: ;
      endcase
   end

   // banks touched by commit, claim and free are always distinct
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int b = 0; b < 2; b++) begin
            r_bst[b]  <= B_EMPTY;
            r_blen[b] <= '0;
         end
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (w_commit && (r_wr_bank == 1'(b))) begin
               r_bst[b]  <= B_FULL;
               r_blen[b] <= w_len_c;
            end
            if (w_claim && (w_iss_bank == 1'(b)))
               r_bst[b] <= B_READING;
            if (w_free && (r_rd_bank == 1'(b)))
               r_bst[b] <= B_EMPTY;
         end
         if (w_commit)
            r_wr_bank <= ~r_wr_bank;
         if (w_free)
            r_rd_bank <= ~r_rd_bank;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_raddr     <= '0;
         r_infl      <= 1'b0;
         r_infl_last <= 1'b0;
         r_out_v     <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_d     <= '0;
         r_sk_v      <= 1'b0;
         r_sk_last   <= 1'b0;
         r_sk_d      <= '0;
      end else begin
         r_infl      <= w_issue;
         r_infl_last <= w_iss_last;
         if (w_issue)
            r_raddr <= w_iss_addr + LP_ONE;
         if (w_xfer) begin
            if (r_sk_v) begin
               r_out_d    <= r_sk_d;
               r_out_last <= r_sk_last;
               r_sk_v     <= r_infl;
               if (r_infl) begin
                  r_sk_d    <= r_mem_q;
                  r_sk_last <= r_infl_last;
               end
            end else if (r_infl) begin
               r_out_d    <= r_mem_q;
               r_out_last <= r_infl_last;
            end else begin
               r_out_v    <= 1'b0;
               r_out_last <= 1'b0;
            end
         end else if (!r_out_v) begin
            if (r_infl) begin
               r_out_v    <= 1'b1;
               r_out_d    <= r_mem_q;
               r_out_last <= r_infl_last;
            end
         end else if (r_infl) begin
            r_sk_v    <= 1'b1;
            r_sk_d    <= r_mem_q;
            r_sk_last <= r_infl_last;
         end
      end
   end

endmodule

// File: tb/tb_dbram_stream_reader.sv
// Directed bench for dbram_stream_reader: fill, commit and stream banks
// under steady and stalling readers, plus reset behaviour.
module tb_dbram_stream_reader;

   logic        clk;
   logic        resetn;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [59:0] wr_data;
   logic        wr_commit;
   logic [11:0] wr_len;
   logic        wr_bank;
   logic        wr_ready;
   logic [59:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        rd_last;
   logic        rd_bank;

   int n_err;
   int n_checks;

   dbram_stream_reader dut (
      .clk       (clk),
      .resetn    (resetn),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_commit (wr_commit),
      .wr_len    (wr_len),
      .wr_bank   (wr_bank),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_last   (rd_last),
      .rd_bank   (rd_bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [59:0] dat(input int i);
      logic [31:0] u;
      u = 32'(i);
      return {28'(u ^ 32'h5A5), u * 32'h9E3779B1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn    = 1'b0;
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      rd_ready  = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic wr_word(input int a, input logic [59:0] d);
      wr_en   = 1'b1;
      wr_addr = 11'(a);
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic commit(input int len);
      wr_commit = 1'b1;
      wr_len    = 12'(len);
      tick();
      wr_commit = 1'b0;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      rd_ready  = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      wr_len    = '0;
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 60'd0) begin
         n_err++;
         $display("FAIL reset_rd: valid=%b last=%b data=%h want 0 0 0",
                  rd_valid, rd_last, rd_data);
      end
      n_checks++;
      if (wr_bank !== 1'b0 || rd_bank !== 1'b0) begin
         n_err++;
         $display("FAIL reset_banks: wr_bank=%b rd_bank=%b want 0 0",
                  wr_bank, rd_bank);
      end
      resetn = 1'b1;
      tick();
      n_checks++;
      if (wr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
      end
   endtask

   task automatic test_basic();
      do_reset();
      rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) wr_word(i, 60'(i));
      commit(8);
      n_checks++;
      if (wr_bank !== 1'b1 || rd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_c0: wr_bank=%b valid=%b want 1 0",
                  wr_bank, rd_valid);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_c1: valid=%b want 0", rd_valid);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 60'(i)
             || rd_last !== (i == 7) || rd_bank !== 1'b0) begin
            n_err++;
            $display("FAIL basic_w%0d: v=%b d=%0d l=%b b=%b want 1 %0d %b 0",
                     i, rd_valid, rd_data, rd_last, rd_bank, i, (i == 7));
         end
         tick();
      end
      n_checks++;
      if (rd_valid !== 1'b0 || rd_bank !== 1'b1 || wr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL basic_end: v=%b rd_bank=%b wr_ready=%b want 0 1 1",
                  rd_valid, rd_bank, wr_ready);
      end
   endtask

   task automatic test_third_commit();
      int k;
      do_reset();
      for (int i = 0; i < 4; i++) wr_word(i, 60'(100 + i));
      commit(4);
      n_checks++;
      if (wr_bank !== 1'b1 || wr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL tc_first: wr_bank=%b wr_ready=%b want 1 1",
                  wr_bank, wr_ready);
      end
      for (int i = 0; i < 3; i++) wr_word(i, 60'(200 + i));
      commit(3);
      n_checks++;
      if (wr_bank !== 1'b0 || wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL tc_second: wr_bank=%b wr_ready=%b want 0 0",
                  wr_bank, wr_ready);
      end
      wr_en     = 1'b1;
      wr_addr   = 11'd3;
      wr_data   = 60'd999;
      wr_commit = 1'b1;
      wr_len    = 12'd5;
      tick();
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      n_checks++;
      if (wr_bank !== 1'b0 || wr_ready !== 1'b0) begin
         n_err++;
         $display("FAIL tc_third: wr_bank=%b wr_ready=%b want 0 0",
                  wr_bank, wr_ready);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         k = 0;
         while (!rd_valid && k < 10) begin
            tick();
            k++;
         end
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 60'(100 + i)
             || rd_last !== (i == 3) || rd_bank !== 1'b0) begin
            n_err++;
            $display("FAIL tc_b0_w%0d: v=%b d=%0d l=%b b=%b want 1 %0d %b 0",
                     i, rd_valid, rd_data, rd_last, rd_bank, 100 + i, (i == 3));
         end
         tick();
      end
      n_checks++;
      if (wr_ready !== 1'b1 || wr_bank !== 1'b0 || rd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL tc_freed: wr_ready=%b wr_bank=%b v=%b want 1 0 0",
                  wr_ready, wr_bank, rd_valid);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 60'(200 + i)
             || rd_last !== (i == 2) || rd_bank !== 1'b1) begin
            n_err++;
            $display("FAIL tc_b1_w%0d: v=%b d=%0d l=%b b=%b want 1 %0d %b 1",
                     i, rd_valid, rd_data, rd_last, rd_bank, 200 + i, (i == 2));
         end
         tick();
      end
      k = 0;
      repeat (4) begin
         if (rd_valid) k++;
         tick();
      end
      n_checks++;
      if (k != 0) begin
         n_err++;
         $display("FAIL tc_no_third: valid cycles=%0d want 0", k);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      wr_word(0, 60'd10);
      wr_word(1, 60'd11);
      commit(2);
      commit(0);
      n_checks++;
      if (wr_bank !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_len0: wr_bank=%b want 1", wr_bank);
      end
      wr_en     = 1'b1;
      wr_addr   = 11'd0;
      wr_data   = 60'd20;
      wr_commit = 1'b1;
      wr_len    = 12'd1;
      tick();
      wr_en     = 1'b0;
      wr_commit = 1'b0;
      rd_ready  = 1'b1;
      n_checks++;
      if (wr_bank !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 60'd10
          || rd_last !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_w0: wb=%b v=%b d=%0d l=%b want 0 1 10 0",
                  wr_bank, rd_valid, rd_data, rd_last);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 60'd11 || rd_last !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_w1: v=%b d=%0d l=%b want 1 11 1",
                  rd_valid, rd_data, rd_last);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_bank !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_gap: v=%b rd_bank=%b want 0 1", rd_valid, rd_bank);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 60'd20 || rd_last !== 1'b1
          || rd_bank !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_len1: v=%b d=%0d l=%b b=%b want 1 20 1 1",
                  rd_valid, rd_data, rd_last, rd_bank);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_bank !== 1'b0 || wr_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_end: v=%b rd_bank=%b wr_ready=%b want 0 0 1",
                  rd_valid, rd_bank, wr_ready);
      end
   endtask

   task automatic test_random_stall();
      int idx;
      int cyc;
      int bad;
      logic pv;
      logic pr;
      logic pl;
      logic pb;
      logic [59:0] pd;
      do_reset();
      for (int i = 0; i < 2048; i++) wr_word(i, dat(i));
      commit(4000);
      idx = 0;
      cyc = 0;
      bad = 0;
      pv  = 1'b0;
      pr  = 1'b0;
      pl  = 1'b0;
      pb  = 1'b0;
      pd  = '0;
      while (idx < 2048 && cyc < 20000) begin
         if (pv && !pr) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl
                || rd_bank !== pb) begin
               n_err++;
               if (bad < 10)
                  $display("FAIL rs_hold: v=%b d=%h l=%b want 1 %h %b",
                           rd_valid, rd_data, rd_last, pd, pl);
               bad++;
            end
         end
         if (rd_valid) begin
            n_checks++;
            if (rd_data !== dat(idx) || rd_last !== (idx == 2047)) begin
               n_err++;
               if (bad < 10)
                  $display("FAIL rs_word%0d: d=%h l=%b want %h %b",
                           idx, rd_data, rd_last, dat(idx), (idx == 2047));
               bad++;
            end
         end
         rd_ready = ($urandom_range(0, 2) != 0);
         pv = rd_valid;
         pr = rd_ready;
         pd = rd_data;
         pl = rd_last;
         pb = rd_bank;
         if (rd_valid && rd_ready) idx++;
         tick();
         cyc++;
      end
      n_checks++;
      if (idx != 2048) begin
         n_err++;
         $display("FAIL rs_count: got %0d words want 2048", idx);
      end
      rd_ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_bank !== 1'b1) begin
         n_err++;
         $display("FAIL rs_end: v=%b rd_bank=%b want 0 1", rd_valid, rd_bank);
      end
   endtask

   task automatic test_reset_midstream();
      int k;
      do_reset();
      for (int i = 0; i < 16; i++) wr_word(i, 60'(50 + i));
      commit(16);
      rd_ready = 1'b1;
      k = 0;
      while (!(rd_valid && rd_data == 60'd55) && k < 20) begin
         tick();
         k++;
      end
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 60'd55) begin
         n_err++;
         $display("FAIL rm_reach5: v=%b d=%0d want 1 55", rd_valid, rd_data);
      end
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 60'd0) begin
         n_err++;
         $display("FAIL rm_async: v=%b l=%b d=%0d want 0 0 0",
                  rd_valid, rd_last, rd_data);
      end
      #1;
      resetn = 1'b1;
      tick();
      n_checks++;
      if (wr_ready !== 1'b1 || wr_bank !== 1'b0 || rd_bank !== 1'b0) begin
         n_err++;
         $display("FAIL rm_after: wr_ready=%b wr_bank=%b rd_bank=%b want 1 0 0",
                  wr_ready, wr_bank, rd_bank);
      end
      k = 0;
      repeat (6) begin
         if (rd_valid) k++;
         tick();
      end
      n_checks++;
      if (k != 0) begin
         n_err++;
         $display("FAIL rm_quiet: valid cycles=%0d want 0", k);
      end
      commit(2);
      k = 0;
      while (!rd_valid && k < 10) begin
         tick();
         k++;
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== 60'(50 + i)
             || rd_last !== (i == 1)) begin
            n_err++;
            $display("FAIL rm_new_w%0d: v=%b d=%0d l=%b want 1 %0d %b",
                     i, rd_valid, rd_data, rd_last, 50 + i, (i == 1));
         end
         tick();
      end
   endtask

   initial begin
      n_err    = 0;
      n_checks = 0;
      test_reset();
      test_basic();
      test_third_commit();
      test_back_to_back();
      test_random_stall();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
